// File: rtl/issue_ls_pkg.sv
// Shared definitions for the load/store issue unit: opcode encoding, widths
// and the controller state encoding.
package issue_ls_pkg;

  localparam logic LS_OP_LOAD  = 1'b1;
  localparam logic LS_OP_STORE = 1'b0;

  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_CDB  = 2'd3
  } ls_state_e;

endpackage

// File: rtl/issue_ls.sv
// Load/store issue unit: accepts one memory instruction at a time, performs
// the data-memory access and broadcasts load results on the CDB.
module issue_ls
  import issue_ls_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issuels_opcode,
  input  logic [TAG_W-1:0]    issuels_rdtag,
  input  logic [DATA_W-1:0]   issuels_addr,
  input  logic [DATA_W-1:0]   issuels_data,
  input  logic                issuels_ready,
  output logic                issuels_done,
  output logic [DATA_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic                dmem_ren,
  output logic                dmem_wen,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_ack,
  output logic                cdb_req,
  input  logic                cdb_grant,
  output logic [TAG_W-1:0]    cdbls_tag,
  output logic [DATA_W-1:0]   cdbls_data,
  output logic                cdbls_valid,
  output logic                ls_err
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  ls_state_e           state_q, state_d;
  logic                op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic aligned;
  logic is_load;

  assign aligned = (addr_q[1:0] == 2'b00);
  assign is_load = (op_q == LS_OP_LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      tag_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (issuels_ready) begin
          op_d    = issuels_opcode;
          tag_d   = issuels_rdtag;
          addr_d  = issuels_addr;
          wdata_d = issuels_data;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (aligned) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = is_load ? ST_CDB : ST_IDLE;
        end
      end

      ST_WAIT: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (dmem_ack) begin
          if (is_load) res_d = dmem_rdata;
          state_d = is_load ? ST_CDB : ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = is_load ? ST_CDB : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CDB: begin
        if (cdb_grant) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign issuels_done = (state_q == ST_IDLE);
  assign dmem_ren     = (state_q == ST_REQ) && aligned && is_load;
  assign dmem_wen     = (state_q == ST_REQ) && aligned && !is_load;
  assign dmem_addr    = {addr_q[DATA_W-1:2], 2'b00};
  assign dmem_wdata   = wdata_q;
  assign cdb_req      = (state_q == ST_CDB);
  assign cdbls_valid  = (state_q == ST_CDB) && cdb_grant;
  assign cdbls_tag    = tag_q;
  assign cdbls_data   = res_q;
  assign ls_err       = err_q;

endmodule
